// File: rtl/i2c_reg_ctrl.sv
// Register-file sequencer behind the i2c slave: first byte after START is a register pointer,
// following bytes are written to the pointed register with pointer auto-increment.
module i2c_reg_ctrl #(
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned PTR_W     = 3,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            data,
    input  logic                  data_valid,
    input  logic                  start,
    input  logic                  stop,
    output logic [8*NUM_REGS-1:0] regs_o,
    output logic                  wr_en_o,
    output logic [PTR_W-1:0]      wr_addr_o,
    output logic [7:0]            wr_data_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StPtr  = 2'd1;
    localparam logic [1:0] StData = 2'd2;
    localparam logic [1:0] StDrop = 2'd3;

    localparam logic [8:0] NumRegs = 9'(NUM_REGS);

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             err_q, err_d;
    logic             wr_en_d;
    logic             ptr_ok;
    logic [7:0]       regs_q [NUM_REGS];

    assign ptr_ok = ({1'b0, data} < NumRegs);

    // start outranks everything else, including a coincident byte or stop.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        wr_en_d = 1'b0;
        if (start) begin
            state_d = StPtr;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StPtr: begin
                    if (data_valid) begin
                        if (ptr_ok) begin
                            ptr_d   = data[PTR_W-1:0];
                            state_d = StData;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StDrop;
                        end
                    end
                    if (stop) begin
                        state_d = StIdle;
                    end
                end
                StData: begin
                    if (data_valid) begin
                        wr_en_d = 1'b1;
                        ptr_d   = ptr_q + 1'b1;
                    end
                    if (stop) begin
                        state_d = StIdle;
                    end
                end
                StDrop: begin
                    if (stop) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    // Write strobe and its address/data are registered; address/data hold between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= 8'h00;
        end else begin
            wr_en_o <= wr_en_d;
            if (wr_en_d) begin
                wr_addr_o <= ptr_q;
                wr_data_o <= data;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                regs_q[k] <= RESET_VAL;
            end else if (wr_en_d && (ptr_q == PTR_W'(k))) begin
                regs_q[k] <= data;
            end
        end
        assign regs_o[8*k +: 8] = regs_q[k];
    end

    assign busy_o = (state_q != StIdle);
    assign err_o  = err_q;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Bench for i2c_reg_ctrl: directed scenarios then random strobes, all checked against a
// transaction-level model of pointer/write behaviour.
module tb_i2c_reg_ctrl;

    localparam int unsigned NUM_REGS  = 8;
    localparam int unsigned PTR_W     = 3;
    localparam logic [7:0]  RESET_VAL = 8'h3C;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [7:0]            data;
    logic                  data_valid;
    logic                  start;
    logic                  stop;
    logic [8*NUM_REGS-1:0] regs_o;
    logic                  wr_en_o;
    logic [PTR_W-1:0]      wr_addr_o;
    logic [7:0]            wr_data_o;
    logic                  busy_o;
    logic                  err_o;

    int checks = 0;
    int errors = 0;
    int wr_count;

    // Reference model, kept in transaction terms.
    logic [7:0] m_regs [NUM_REGS];
    int         m_ptr;
    bit         m_open, m_need_ptr, m_drop, m_err, m_wr_en;
    int         m_wr_addr;
    logic [7:0] m_wr_data;

    i2c_reg_ctrl #(
        .NUM_REGS (NUM_REGS),
        .PTR_W    (PTR_W),
        .RESET_VAL(RESET_VAL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .data_valid(data_valid),
        .start     (start),
        .stop      (stop),
        .regs_o    (regs_o),
        .wr_en_o   (wr_en_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8*NUM_REGS-1:0] model_flat();
        logic [8*NUM_REGS-1:0] v;
        for (int k = 0; k < NUM_REGS; k++) v[8*k +: 8] = m_regs[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_REGS; k++) m_regs[k] = RESET_VAL;
        m_ptr = 0; m_open = 0; m_need_ptr = 0; m_drop = 0; m_err = 0;
        m_wr_en = 0; m_wr_addr = 0; m_wr_data = 8'h00;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit dv, input logic [7:0] d);
        m_wr_en = 0;
        if (st) begin
            m_open = 1; m_need_ptr = 1; m_drop = 0; m_err = 0;
        end else if (m_open) begin
            if (dv && !m_drop) begin
                if (m_need_ptr) begin
                    if (int'(d) < NUM_REGS) begin
                        m_ptr = int'(d);
                        m_need_ptr = 0;
                    end else begin
                        m_err = 1;
                        m_drop = 1;
                    end
                end else begin
                    m_regs[m_ptr] = d;
                    m_wr_en = 1;
                    m_wr_addr = m_ptr;
                    m_wr_data = d;
                    m_ptr = (m_ptr + 1) % NUM_REGS;
                end
            end
            if (sp) m_open = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".regs"}, 64'(regs_o), 64'(model_flat()));
        check({tag, ".wr_en"}, 64'(wr_en_o), 64'(m_wr_en));
        check({tag, ".wr_addr"}, 64'(wr_addr_o), 64'(m_wr_addr));
        check({tag, ".wr_data"}, 64'(wr_data_o), 64'(m_wr_data));
        check({tag, ".busy"}, 64'(busy_o), 64'(m_open));
        check({tag, ".err"}, 64'(err_o), 64'(m_err));
    endtask

    task automatic cyc(input string tag, input bit st, input bit sp, input bit dv,
                       input logic [7:0] d);
        @(negedge clk);
        start = st; stop = sp; data_valid = dv; data = d;
        @(posedge clk);
        #1;
        start = 0; stop = 0; data_valid = 0;
        model_step(st, sp, dv, d);
        compare_all(tag);
        if (wr_en_o) wr_count++;
    endtask

    initial begin
        reset = 1; start = 0; stop = 0; data_valid = 0; data = 8'h00;
        model_reset();
        #1;
        check("async_reset_regs", 64'(regs_o), 64'(model_flat()));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        compare_all("reset_state");
        check("reset_ptr", 64'(dut.ptr_q), 64'd0);

        // Basic write to reg2.
        wr_count = 0;
        cyc("t1_start", 1, 0, 0, 8'h00);
        cyc("t1_ptr", 0, 0, 1, 8'h02);
        cyc("t1_dat", 0, 0, 1, 8'hA5);
        check("t1_reg2", 64'(regs_o[23:16]), 64'hA5);
        check("t1_wr_addr", 64'(wr_addr_o), 64'd2);
        cyc("t1_stop", 0, 1, 0, 8'h00);
        check("t1_busy_low", 64'(busy_o), 64'd0);
        check("t1_one_pulse", 64'(wr_count), 64'd1);

        // Pointer wraps from 7 to 0 without error.
        cyc("t2_start", 1, 0, 0, 8'h00);
        cyc("t2_ptr", 0, 0, 1, 8'h06);
        cyc("t2_d0", 0, 0, 1, 8'h11);
        cyc("t2_d1", 0, 0, 1, 8'h22);
        cyc("t2_d2", 0, 0, 1, 8'h33);
        check("t2_reg6", 64'(regs_o[55:48]), 64'h11);
        check("t2_reg7", 64'(regs_o[63:56]), 64'h22);
        check("t2_reg0", 64'(regs_o[7:0]), 64'h33);
        check("t2_no_err", 64'(err_o), 64'd0);
        cyc("t2_stop", 0, 1, 0, 8'h00);

        // Out-of-range pointer sets err and drops data.
        wr_count = 0;
        cyc("t3_start", 1, 0, 0, 8'h00);
        cyc("t3_ptr", 0, 0, 1, 8'h09);
        check("t3_err", 64'(err_o), 64'd1);
        cyc("t3_dat", 0, 0, 1, 8'h55);
        check("t3_no_write", 64'(wr_count), 64'd0);
        cyc("t3_restart", 1, 0, 0, 8'h00);
        check("t3_err_cleared", 64'(err_o), 64'd0);
        cyc("t3_stop", 0, 1, 0, 8'h00);

        // Repeated START; byte coincident with start is discarded.
        cyc("t4_start", 1, 0, 0, 8'h00);
        cyc("t4_ptr", 0, 0, 1, 8'h01);
        cyc("t4_d", 0, 0, 1, 8'h10);
        cyc("t4_rstart_dv", 1, 0, 1, 8'hEE);
        check("t4_no_wr_on_start", 64'(wr_en_o), 64'd0);
        cyc("t4_ptr2", 0, 0, 1, 8'h04);
        cyc("t4_d2", 0, 0, 1, 8'h20);
        check("t4_reg1", 64'(regs_o[15:8]), 64'h10);
        check("t4_reg4", 64'(regs_o[39:32]), 64'h20);
        cyc("t4_stop", 0, 1, 0, 8'h00);

        // stop with a data byte: byte written, then idle.
        cyc("t5_start", 1, 0, 0, 8'h00);
        cyc("t5_ptr", 0, 0, 1, 8'h03);
        cyc("t5_dat_stop", 0, 1, 1, 8'h77);
        check("t5_reg3", 64'(regs_o[31:24]), 64'h77);
        check("t5_idle", 64'(busy_o), 64'd0);
        cyc("t5_stray", 0, 0, 1, 8'h88);
        check("t5_stray_no_wr", 64'(wr_en_o), 64'd0);

        // stop with pointer byte: pointer loaded, then idle.
        cyc("t6_start", 1, 0, 0, 8'h00);
        cyc("t6_ptr_stop", 0, 1, 1, 8'h05);
        cyc("t6_stray", 0, 0, 1, 8'h66);
        cyc("t6_both", 1, 1, 0, 8'h00);
        check("t6_start_wins", 64'(busy_o), 64'd1);
        cyc("t6_stop", 0, 1, 0, 8'h00);

        // Reset between two data bytes aborts immediately.
        cyc("t7_start", 1, 0, 0, 8'h00);
        cyc("t7_ptr", 0, 0, 1, 8'h05);
        cyc("t7_d0", 0, 0, 1, 8'h11);
        @(negedge clk);
        data_valid = 1; data = 8'h99;
        #1 reset = 1;
        #1;
        model_reset();
        compare_all("t7_async");
        check("t7_ptr_zero", 64'(dut.ptr_q), 64'd0);
        @(posedge clk);
        #1;
        check("t7_no_wr", 64'(wr_en_o), 64'd0);
        check("t7_busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        reset = 0; data_valid = 0;

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            bit st, sp, dv;
            logic [7:0] d;
            st = ($urandom_range(0, 99) < 10);
            sp = ($urandom_range(0, 99) < 8);
            dv = ($urandom_range(0, 99) < 55);
            d  = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            cyc("rand", st, sp, dv, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
